lfsr_scrambler_gen: RTL and testbench
=====================================

# lfsr_scrambler_gen

- Parametrised multi-step Galois LFSR keystream generator for the data scrambler path.
- Generalises the fixed 96-bit/15-step primary LFSR: width, tap mask, steps per advance, output width and register base address are all parameters.
- Adds a ready/valid output handshake, a seed shadow register with optional periodic auto-reseed, lock-up (all-zero) detection, and a status readback port.
- Sits between the register bus and the data selector. It supplies OUT_BITS of keystream per accepted advance.

## Interface

- POLY_WIDTH, 96: LFSR state width (≥32, multiple of 32).
- STEPS, 15: single-bit LFSR steps per advance (1..POLY_WIDTH-1).
- OUT_BITS, 10: keystream bits per advance (≤POLY_WIDTH).
- TAPS, 96'h00020000_00000000_00028001: Galois feedback mask. Bit i set means state bit i receives the feedback bit.
- BASE_ADDR, 12'h06a: register base address; NW = POLY_WIDTH/32 seed words.
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-high.
- write in 1: register write strobe.
- read in 1: register read strobe.
- addr in 12: register address.
- wdata in 32: write data.
- rdata out 32: read data, valid the cycle after read.
- out_ready in 1: consumer accepts the keystream.
- out_valid out 1: keystream valid.
- bits_stream out OUT_BITS: bits_stream[k] = state[POLY_WIDTH-1-k].
- dout out POLY_WIDTH: current LFSR state.
- lockup out 1: sticky all-zero-state flag.

## Operation

**Single step.** With fb = s[W-1]:
- next[0] = fb & TAPS[0]
- next[i] = s[i-1] ^ (fb & TAPS[i])

An advance applies STEPS single steps combinationally.

**Register map.**
- BASE+j, j<NW: seed word j, holding bits 32j+31:32j. Writes always update the seed shadow. In IDLE they also update the state.
- BASE+NW: CTRL.
  - bit0 run
  - bit1 auto_reseed
  - bits31:16 reseed interval R
  - CTRL is read/write.
- BASE+NW+1: STATUS, read-only.
  - bits1:0 FSM state
  - bit2 lockup
  - bits31:16 advance counter
- Reads of any other address return 0. Writes to other addresses are ignored.

**FSM.**
- IDLE → RUN when run=1.
- RUN → IDLE when run=0.
- RUN → RELOAD when auto_reseed=1, R≠0, and the advance counter reaches R on an accepted advance.
- RELOAD → RUN after 1 cycle. In RELOAD, state ← shadow, the counter clears, and out_valid=0.
- If run=0 is written during RELOAD, the reload still completes and the FSM then goes to IDLE.

**Handshake.**
- out_valid = (FSM==RUN) & ~lockup.
- An advance occurs only on out_valid & out_ready. Otherwise state and bits_stream are held.

**Counter.**
- 16-bit advance counter. It increments per advance and wraps at 0xFFFF→0.
- It clears on entry to RELOAD and on any CTRL write.

**Lock-up.**
- lockup sets when state==0 in RUN. It blocks out_valid.
- A seed-word write clears it. The seed write takes priority over setting lockup in the same cycle.

**Simultaneous events.**
- A seed write in RUN coinciding with an advance: the shadow is updated and the state advances.
- A CTRL write coinciding with an advance: the advance completes and the new CTRL takes effect next cycle.
- Reset mid-operation clears everything immediately.

## Timing

- Reset values: state 0, shadow 0, CTRL 0, counter 0, FSM IDLE, rdata 0, out_valid 0, lockup 0, bits_stream 0.
- Register writes take effect on the next clock edge.
- rdata has one-cycle latency and holds its value until the next read.
- Advance latency is 1 cycle: the new bits_stream is visible the cycle after acceptance.
- Back-to-back advances are possible, one per cycle.
- RELOAD costs exactly one bubble cycle.
- run=1 written in IDLE produces out_valid=1 on the following cycle, provided state≠0.

## Structure

- Package lfsr_scrambler_pkg holds:
  - FSM enum (IDLE=0, RUN=1, RELOAD=2)
  - register offsets (SEED0, CTRL=NW, STATUS=NW+1)
  - CTRL field positions
  - default TAPS constant
- One sub-module, lfsr_multistep: purely combinational, parametrised by POLY_WIDTH/STEPS/TAPS, computing state after STEPS Galois steps.

## Test plan

- Seed word0=1, others 0, run=1, out_ready=1 for one cycle → state 96'h8000, bits_stream 10'h000, counter 1.
- Seed only bit95 set (word2=32'h80000000), one advance → state 96'h80000000_00000000_A0004000, bits_stream 10'h001.
- run=1 with zero seed → lockup=1, out_valid=0. Then write seed word0=1 → lockup=0, and out_valid=1 the next cycle.
- auto_reseed=1, R=3, out_ready held high → three advances, one RELOAD bubble, then state equals seed and counter=0. The sequence repeats identically.
- Hold out_ready=0 for 5 cycles in RUN → state and bits_stream unchanged. Assert rst mid-RUN → all outputs return to reset values asynchronously.
- Read STATUS after 2 advances in RUN → rdata 32'h0002_0001 one cycle after read. Read an unmapped address → 0.

Source files
------------

// File: rtl/lfsr_scrambler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_scrambler_pkg
//  Purpose  : Shared constants for the scrambler keystream generator:
//             FSM state encodings, register offsets relative to the block
//             base address, CTRL/STATUS field positions and default taps.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package lfsr_scrambler_pkg;

    // FSM state encodings (2-bit, also exposed in STATUS[1:0])
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_RELOAD = 2'd2;

    // Register offsets from the base address. Seed words occupy
    // [c_OFF_SEED0, c_OFF_SEED0+nw), followed by CTRL and STATUS.
    localparam int c_OFF_SEED0 = 0;

    function automatic logic [11:0] off_ctrl(input int nw);
        return 12'(c_OFF_SEED0 + nw);
    endfunction

    function automatic logic [11:0] off_status(input int nw);
        return 12'(c_OFF_SEED0 + nw + 1);
    endfunction

    // CTRL field positions
    localparam int c_CTRL_RUN      = 0;
    localparam int c_CTRL_AUTO     = 1;
    localparam int c_CTRL_INTV_LSB = 16;

    // STATUS field positions
    localparam int c_STAT_FSM_LSB  = 0;
    localparam int c_STAT_LOCK     = 2;
    localparam int c_STAT_CNT_LSB  = 16;

    // Default feedback mask for the 96-bit primary scrambler polynomial
    localparam logic [95:0] c_DEF_TAPS = 96'h00020000_00000000_00028001;

endpackage
`default_nettype wire

// File: rtl/lfsr_multistep.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_multistep
//  Purpose  : Purely combinational STEPS-fold Galois LFSR advance.
//             One step: fb = s[W-1]; next = (s << 1) ^ (TAPS & {W{fb}}).
//  Ports    : state_in  [POLY_WIDTH] - current LFSR state
//             state_out [POLY_WIDTH] - state after STEPS single steps
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr_multistep
    import lfsr_scrambler_pkg::*;
#(
    parameter int                    POLY_WIDTH = 96,
    parameter int                    STEPS      = 15,
    parameter logic [POLY_WIDTH-1:0] TAPS       = c_DEF_TAPS
) (
    input  logic [POLY_WIDTH-1:0] state_in,
    output logic [POLY_WIDTH-1:0] state_out
);

    logic [POLY_WIDTH-1:0] w_acc;

    // Unrolled by synthesis into a STEPS-deep XOR network.
    always_comb begin
        w_acc = state_in;
        for (int s = 0; s < STEPS; s++) begin
            w_acc = {w_acc[POLY_WIDTH-2:0], 1'b0} ^ (TAPS & {POLY_WIDTH{w_acc[POLY_WIDTH-1]}});
        end
    end

    assign state_out = w_acc;

endmodule
`default_nettype wire

// File: rtl/lfsr_scrambler_gen.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_scrambler_gen
//  Purpose  : Parametrised multi-step Galois LFSR keystream generator with a
//             register interface (seed shadow, CTRL, STATUS), ready/valid
//             keystream handshake, optional periodic auto-reseed and sticky
//             all-zero lock-up detection.
//  Ports    : clk, rst              - clock, async active-high reset
//             write, read, addr,
//             wdata, rdata          - register bus (rdata: 1-cycle latency)
//             out_ready, out_valid  - keystream handshake
//             bits_stream[OUT_BITS] - bits_stream[k] = state[POLY_WIDTH-1-k]
//             dout[POLY_WIDTH]      - current LFSR state
//             lockup                - sticky all-zero-state flag
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr_scrambler_gen
    import lfsr_scrambler_pkg::*;
#(
    parameter int                    POLY_WIDTH = 96,
    parameter int                    STEPS      = 15,
    parameter int                    OUT_BITS   = 10,
    parameter logic [POLY_WIDTH-1:0] TAPS       = c_DEF_TAPS,
    parameter logic [11:0]           BASE_ADDR  = 12'h06a
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic                  read,
    input  logic [11:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [OUT_BITS-1:0]   bits_stream,
    output logic [POLY_WIDTH-1:0] dout,
    output logic                  lockup
);

    localparam int          c_NW         = POLY_WIDTH / 32;
    localparam logic [11:0] c_OFF_CTRL   = off_ctrl(c_NW);
    localparam logic [11:0] c_OFF_STATUS = off_status(c_NW);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [POLY_WIDTH-1:0] r_state;
    logic [POLY_WIDTH-1:0] r_shadow;
    logic                  r_run;
    logic                  r_auto;
    logic [15:0]           r_intv;
    logic [15:0]           r_cnt;
    logic [1:0]            r_fsm;
    logic                  r_lockup;
    logic [31:0]           r_rdata;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [11:0] w_off;
    logic [11:0] w_seed_idx;
    logic        w_seed_hit;
    logic        w_ctrl_hit;
    logic        w_stat_hit;
    logic        w_seed_wr;
    logic        w_ctrl_wr;

    // Addresses below the base wrap to large offsets and so miss every range.
    assign w_off      = addr - BASE_ADDR;
    assign w_seed_idx = w_off - 12'(c_OFF_SEED0);
    assign w_seed_hit = (w_seed_idx < 12'(c_NW));
    assign w_ctrl_hit = (w_off == c_OFF_CTRL);
    assign w_stat_hit = (w_off == c_OFF_STATUS);
    assign w_seed_wr  = write & w_seed_hit;
    assign w_ctrl_wr  = write & w_ctrl_hit;

    // ------------------------------------------------------------------
    // Advance datapath and handshake
    // ------------------------------------------------------------------
    logic [POLY_WIDTH-1:0] w_adv_state;
    logic                  w_adv;
    logic [15:0]           w_cnt_inc;
    logic                  w_reload_hit;
    logic                  w_run_eff;
    logic [1:0]            w_fsm_nxt;

    lfsr_multistep #(
        .POLY_WIDTH (POLY_WIDTH),
        .STEPS      (STEPS),
        .TAPS       (TAPS)
    ) u_multistep (
        .state_in   (r_state),
        .state_out  (w_adv_state)
    );

    assign out_valid    = (r_fsm == c_ST_RUN) & ~r_lockup;
    assign w_adv        = out_valid & out_ready;
    assign w_cnt_inc    = r_cnt + 16'd1;
    assign w_reload_hit = w_adv & r_auto & (r_intv != 16'd0) & (w_cnt_inc == r_intv);

    // A run-bit write steers the very next FSM state, so run=1 written in
    // IDLE gives out_valid on the following cycle.
    assign w_run_eff    = w_ctrl_wr ? wdata[c_CTRL_RUN] : r_run;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= c_ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            c_ST_IDLE: begin
                if (w_run_eff) w_fsm_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (!w_run_eff)        w_fsm_nxt = c_ST_IDLE;
                else if (w_reload_hit) w_fsm_nxt = c_ST_RELOAD;
            end
            c_ST_RELOAD: begin
                // The reload always completes; run only picks the exit.
                w_fsm_nxt = w_run_eff ? c_ST_RUN : c_ST_IDLE;
            end
            default: w_fsm_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // LFSR state and seed shadow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
        end else if (r_fsm == c_ST_RELOAD) begin
            r_state <= r_shadow;
        end else begin
            if (w_adv) r_state <= w_adv_state;
            // Seed words load the live state in IDLE, and also while locked
            // up so a fresh seed can revive a stuck generator. Neither case
            // can coincide with an advance since out_valid is low then.
            if (w_seed_wr && ((r_fsm == c_ST_IDLE) || r_lockup)) begin
                for (int j = 0; j < c_NW; j++) begin
                    if (w_seed_idx == 12'(j)) r_state[32*j +: 32] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (w_seed_wr) begin
            for (int j = 0; j < c_NW; j++) begin
                if (w_seed_idx == 12'(j)) r_shadow[32*j +: 32] <= wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // CTRL, advance counter, lock-up flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run  <= 1'b0;
            r_auto <= 1'b0;
            r_intv <= 16'd0;
        end else if (w_ctrl_wr) begin
            r_run  <= wdata[c_CTRL_RUN];
            r_auto <= wdata[c_CTRL_AUTO];
            r_intv <= wdata[c_CTRL_INTV_LSB +: 16];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 16'd0;
        end else if (w_ctrl_wr || (w_fsm_nxt == c_ST_RELOAD) || (r_fsm == c_ST_RELOAD)) begin
            r_cnt <= 16'd0;
        end else if (w_adv) begin
            r_cnt <= w_cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lockup <= 1'b0;
        end else if (w_seed_wr) begin
            r_lockup <= 1'b0;
        end else if ((r_fsm == c_ST_RUN) && (r_state == '0)) begin
            r_lockup <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Register readback (one-cycle latency, held between reads)
    // ------------------------------------------------------------------
    logic [31:0] w_rd_mux;

    always_comb begin
        w_rd_mux = 32'd0;
        if (w_seed_hit) begin
            for (int j = 0; j < c_NW; j++) begin
                if (w_seed_idx == 12'(j)) w_rd_mux = r_shadow[32*j +: 32];
            end
        end else if (w_ctrl_hit) begin
            w_rd_mux[c_CTRL_RUN]            = r_run;
            w_rd_mux[c_CTRL_AUTO]           = r_auto;
            w_rd_mux[c_CTRL_INTV_LSB +: 16] = r_intv;
        end else if (w_stat_hit) begin
            w_rd_mux[c_STAT_FSM_LSB +: 2]   = r_fsm;
            w_rd_mux[c_STAT_LOCK]           = r_lockup;
            w_rd_mux[c_STAT_CNT_LSB +: 16]  = r_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'd0;
        end else if (read) begin
            r_rdata <= w_rd_mux;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar k = 0; k < OUT_BITS; k++) begin : g_bits
        assign bits_stream[k] = r_state[POLY_WIDTH-1-k];
    end

    assign dout   = r_state;
    assign lockup = r_lockup;
    assign rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_scrambler_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_scrambler_gen
//  Purpose  : Self-checking bench for lfsr_scrambler_gen: seed/advance
//             vector table with an advance scoreboard, plus hand sequences
//             for lock-up, hold, auto-reseed, readback and async reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_scrambler_gen;

    localparam logic [95:0] TB_TAPS   = 96'h00020000_00000000_00028001;
    localparam logic [11:0] A_SEED0   = 12'h06a;
    localparam logic [11:0] A_SEED1   = 12'h06b;
    localparam logic [11:0] A_SEED2   = 12'h06c;
    localparam logic [11:0] A_CTRL    = 12'h06d;
    localparam logic [11:0] A_STATUS  = 12'h06e;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [11:0] addr = 12'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [9:0]  bits_stream;
    logic [95:0] dout;
    logic        lockup;

    lfsr_scrambler_gen dut (
        .clk         (clk),
        .rst         (rst),
        .write       (write),
        .read        (read),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .bits_stream (bits_stream),
        .dout        (dout),
        .lockup      (lockup)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [95:0] m_state;
    logic [95:0] sb_q[$];

    typedef struct {
        logic [95:0] seed;
        int          n_adv;
        bit          has_const;
        logic [95:0] exp_state;
        logic [9:0]  exp_bits;
    } vec_t;

    vec_t vecs[5];

    // Bit-serial reference of one Galois advance (15 single steps).
    function automatic logic [95:0] ref_adv(input logic [95:0] s);
        logic [95:0] n;
        logic        fb;
        for (int st = 0; st < 15; st++) begin
            fb   = s[95];
            n[0] = fb & TB_TAPS[0];
            for (int i = 1; i < 96; i++) n[i] = s[i-1] ^ (fb & TB_TAPS[i]);
            s = n;
        end
        return s;
    endfunction

    function automatic logic [9:0] ref_bits(input logic [95:0] s);
        logic [9:0] b;
        for (int k = 0; k < 10; k++) b[k] = s[95-k];
        return b;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic do_write(input logic [11:0] a, input logic [31:0] d);
        write = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] a, output logic [31:0] d);
        read = 1'b1; addr = a;
        @(negedge clk);
        read = 1'b0;
        d = rdata;
    endtask

    task automatic load_seed(input logic [95:0] s);
        do_write(A_SEED0, s[31:0]);
        do_write(A_SEED1, s[63:32]);
        do_write(A_SEED2, s[95:64]);
    endtask

    // Drives n accepted advances; each expected state is queued when the
    // handshake is driven and compared the cycle the DUT shows it.
    task automatic adv_cycles(input int n);
        logic [95:0] e;
        for (int i = 0; i < n; i++) begin
            chk("adv_valid", {95'd0, out_valid}, 96'd1);
            out_ready = 1'b1;
            m_state = ref_adv(m_state);
            sb_q.push_back(m_state);
            @(negedge clk);
            out_ready = 1'b0;
            e = sb_q.pop_front();
            chk("adv_state", dout, e);
            chk("adv_bits", {86'd0, bits_stream}, {86'd0, ref_bits(e)});
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [95:0] seq[4];

        vecs[0] = '{96'h1, 1, 1'b1, 96'h8000, 10'h000};
        vecs[1] = '{96'h80000000_00000000_00000000, 1, 1'b1, 96'h80000000_00000000_A0004000, 10'h001};
        vecs[2] = '{96'hDEADBEEF_01234567_89ABCDEF, 2, 1'b0, 96'h0, 10'h0};
        vecs[3] = '{96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 3, 1'b0, 96'h0, 10'h0};
        vecs[4] = '{96'h00000000_80000000_00000000, 5, 1'b0, 96'h0, 10'h0};

        // ---- reset values ----
        #2;
        chk("rst_dout", dout, 96'd0);
        chk("rst_valid", {95'd0, out_valid}, 96'd0);
        chk("rst_lockup", {95'd0, lockup}, 96'd0);
        chk("rst_bits", {86'd0, bits_stream}, 96'd0);
        chk("rst_rdata", {64'd0, rdata}, 96'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---- table-driven seed / advance vectors ----
        for (int v = 0; v < 5; v++) begin
            do_write(A_CTRL, 32'd0);
            load_seed(vecs[v].seed);
            chk("idle_seed_state", dout, vecs[v].seed);
            do_write(A_CTRL, 32'h0000_0001);
            chk("run_valid", {95'd0, out_valid}, 96'd1);
            m_state = vecs[v].seed;
            adv_cycles(vecs[v].n_adv);
            if (vecs[v].has_const) begin
                chk("const_state", dout, vecs[v].exp_state);
                chk("const_bits", {86'd0, bits_stream}, {86'd0, vecs[v].exp_bits});
            end
            do_read(A_STATUS, rd);
            chk("status_cnt", {64'd0, rd}, {64'd0, 16'(vecs[v].n_adv), 16'h0001});
        end

        // ---- readback: seed shadow, CTRL, unmapped, hold ----
        do_read(A_SEED1, rd);
        chk("rd_seed1", {64'd0, rd}, {64'd0, 32'h8000_0000});
        do_write(A_CTRL, 32'h1234_0001);
        do_read(A_CTRL, rd);
        chk("rd_ctrl", {64'd0, rd}, {64'd0, 32'h1234_0001});
        @(negedge clk);
        @(negedge clk);
        chk("rd_hold", {64'd0, rdata}, {64'd0, 32'h1234_0001});
        do_read(12'h06f, rd);
        chk("rd_unmapped_hi", {64'd0, rd}, 96'd0);
        do_read(12'h069, rd);
        chk("rd_unmapped_lo", {64'd0, rd}, 96'd0);

        // ---- lock-up on zero seed, recovery by seed write ----
        do_write(A_CTRL, 32'd0);
        load_seed(96'd0);
        do_write(A_CTRL, 32'h0000_0001);
        @(negedge clk);
        chk("lock_set", {95'd0, lockup}, 96'd1);
        chk("lock_valid", {95'd0, out_valid}, 96'd0);
        do_read(A_STATUS, rd);
        chk("lock_status", {64'd0, rd}, {64'd0, 32'h0000_0005});
        do_write(A_SEED0, 32'h1);
        chk("lock_clr", {95'd0, lockup}, 96'd0);
        chk("lock_recover_valid", {95'd0, out_valid}, 96'd1);
        chk("lock_recover_state", dout, 96'h1);

        // ---- hold with out_ready low ----
        m_state = 96'h1;
        adv_cycles(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_state", dout, m_state);
            chk("hold_bits", {86'd0, bits_stream}, {86'd0, ref_bits(m_state)});
        end
        chk("hold_valid", {95'd0, out_valid}, 96'd1);

        // ---- auto-reseed every 3 advances ----
        do_write(A_CTRL, 32'd0);
        load_seed(96'h1);
        seq[0] = 96'h1;
        for (int i = 1; i < 4; i++) seq[i] = ref_adv(seq[i-1]);
        out_ready = 1'b1;
        do_write(A_CTRL, 32'h0003_0003);
        for (int c = 0; c < 8; c++) begin
            chk("reseed_state", dout, seq[c % 4]);
            chk("reseed_valid", {95'd0, out_valid}, {95'd0, (c % 4) != 3});
            if (c == 7) out_ready = 1'b0;
            @(negedge clk);
        end
        chk("reseed_final_state", dout, 96'h1);
        do_read(A_STATUS, rd);
        chk("reseed_status", {64'd0, rd}, {64'd0, 32'h0000_0001});

        // ---- asynchronous reset mid-RUN ----
        out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_dout", dout, 96'd0);
        chk("arst_valid", {95'd0, out_valid}, 96'd0);
        chk("arst_lockup", {95'd0, lockup}, 96'd0);
        chk("arst_bits", {86'd0, bits_stream}, 96'd0);
        chk("arst_rdata", {64'd0, rdata}, 96'd0);
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_read(A_CTRL, rd);
        chk("arst_ctrl", {64'd0, rd}, 96'd0);
        do_read(A_STATUS, rd);
        chk("arst_status", {64'd0, rd}, 96'd0);
        do_read(A_SEED0, rd);
        chk("arst_shadow", {64'd0, rd}, 96'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
